// File: rtl/vctrl_pkg.sv
// Shared definitions for the vector control pipeline: default control-word
// bit positions, sequencer state encoding and the beat-index width helper.
package vctrl_pkg;

  localparam int MEMTOREG    = 7;
  localparam int MEMWRITE    = 6;
  localparam int ALUSRC      = 5;
  localparam int REGDST      = 4;
  localparam int REGWRITE    = 3;
  localparam int ALUCTRL_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  // A single-beat configuration still gets a one-bit beat field.
  function automatic int beat_width(input int vlen, input int lanes);
    int beats;
    beats = vlen / lanes;
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/vctrl_pipe_stage.sv
// One pipeline register holding a packed {valid, last, beat, ctrl} micro-op.
// Clear loads a bubble (all zero); enable loads d_i.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vctrl_pipe.sv
// Control-word pipeline behind Decode with a beat sequencer that splits vector
// instructions into VLEN/LANES micro-ops and holds Decode until the last beat.
module vctrl_pipe
  import vctrl_pkg::*;
#(
  parameter int CW      = 8,
  parameter int NSTAGES = 3,
  parameter int VLEN    = 8,
  parameter int LANES   = 4,
  localparam int BW     = beat_width(VLEN, LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         ctrlD,
  input  logic                  validD,
  input  logic                  vectorD,
  input  logic                  stall_i,
  input  logic                  kill_i,
  output logic                  busyD,
  output logic [NSTAGES*CW-1:0] ctrl_o,
  output logic [NSTAGES-1:0]    valid_o,
  output logic [NSTAGES*BW-1:0] beat_o,
  output logic [NSTAGES-1:0]    last_o
);

  localparam int BEATS = VLEN / LANES;
  localparam int SW    = CW + BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  seq_state_e    state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          issue, multi, issue_last;
  logic [BW-1:0] issue_beat;
  logic [SW-1:0] stage_q [NSTAGES];

  always_comb begin
    issue      = validD & ~stall_i & ~kill_i;
    multi      = vectorD && (BEATS > 1);
    issue_beat = (state_q == ISSUE) ? cnt_q : '0;
    issue_last = (state_q == ISSUE) ? (cnt_q == LAST_BEAT) : ~multi;
    busyD      = stall_i | (issue & multi & (issue_beat != LAST_BEAT));

    state_d = state_q;
    cnt_d   = cnt_q;
    // Kill aborts the sequence even when a stall is raised in the same cycle.
    if (kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (issue) begin
      if (state_q == IDLE) begin
        if (multi) begin
          state_d = ISSUE;
          cnt_d   = BW'(1);
        end
      end else if (cnt_q == LAST_BEAT) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only stage 0 sees bubbles injected; later stages simply shift.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        pipe_stage #(.W(SW)) u_stage (
          .clk   (clk),
          .reset (reset),
          .clr   (~issue),
          .en    (1'b1),
          .d_i   ({1'b1, issue_last, issue_beat, ctrlD}),
          .q_o   (stage_q[gi])
        );
      end else begin : g_tail
        pipe_stage #(.W(SW)) u_stage (
          .clk   (clk),
          .reset (reset),
          .clr   (1'b0),
          .en    (1'b1),
          .d_i   (stage_q[gi-1]),
          .q_o   (stage_q[gi])
        );
      end

      assign valid_o[gi]           = stage_q[gi][SW-1];
      assign last_o[gi]            = stage_q[gi][SW-2];
      assign beat_o[gi*BW +: BW]   = stage_q[gi][CW +: BW];
      assign ctrl_o[gi*CW +: CW]   = stage_q[gi][CW-1:0];
    end
  endgenerate

endmodule

// File: doc/vctrl_pipe.md
# vctrl_pipe

Parametrised control-signal pipeline for the vector processor. It takes the decoded control word from the Decode stage and carries it through a configurable number of downstream stages (Execute, Memory, Writeback by default). A built-in beat sequencer splits each vector instruction into `VLEN/LANES` micro-op beats, one per cycle, and holds Decode until the last beat has issued. It also supports per-cycle stall and kill from the hazard unit.

## Interface
- `CW`, 8: control word width (memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[2:0] in default packing)
- `NSTAGES`, 3: number of pipeline stages after Decode; stage 0 = E, stage NSTAGES-1 = W; legal range 1..8
- `VLEN`, 8: elements per vector register
- `LANES`, 4: elements processed per beat; `VLEN` must be an integer multiple of `LANES`
- `clk`, in, 1: the one clock; all state updates on its rising edge
- `reset`, in, 1: synchronous, active-high
- `ctrlD`, in, CW: decoded control word
- `validD`, in, 1: Decode holds a real instruction
- `vectorD`, in, 1: instruction is a vector op (multi-beat)
- `stall_i`, in, 1: hazard stall; inject bubble into stage 0 and hold the sequencer
- `kill_i`, in, 1: branch/redirect kill; inject bubble and abort any in-progress vector sequence
- `busyD`, out, 1: Decode (and Fetch) must hold their current contents
- `ctrl_o`, out, NSTAGES×CW: control word per stage
- `valid_o`, out, NSTAGES: stage holds a real micro-op
- `beat_o`, out, NSTAGES×BW: beat index per stage; BW = max(1, clog2(VLEN/LANES))
- `last_o`, out, NSTAGES: micro-op is the final beat of its instruction (always 1 for scalar)

## Operation
- BEATS = VLEN/LANES.
- Sequencer FSM has two states:
  - IDLE: counter = 0.
  - ISSUE: counter = index of the next beat to issue.
- Issue condition: validD & ~stall_i & ~kill_i.
  - A scalar instruction, or a vector instruction with BEATS = 1, issues one micro-op with beat = 0, last = 1. FSM stays IDLE.
  - A vector instruction in IDLE issues beat 0. If BEATS > 1, FSM goes to ISSUE with counter = 1.
  - In ISSUE, each issue cycle sends beat = counter and increments the counter. When counter = BEATS-1 that beat has last = 1, and FSM returns to IDLE with counter = 0.
- Every issued micro-op carries `ctrlD` unchanged.
- stall_i: stage 0 loads a bubble; FSM and counter hold.
- kill_i: stage 0 loads a bubble; FSM goes to IDLE with counter = 0. Stages 1..NSTAGES-1 are unaffected.
- kill_i with stall_i in the same cycle: kill wins.
- A bubble has valid = 0, ctrl = 0, beat = 0, last = 0. All write enables are therefore inactive.
- Stage k ≥ 1 loads stage k-1 unconditionally every cycle. There is no back-pressure beyond stage 0.
- busyD = stall_i | (issue condition & vectorD & BEATS > 1 & beat issued this cycle ≠ BEATS-1). It is combinational from inputs and FSM state.
- validD = 0 while in ISSUE (malformed upstream): stage 0 gets a bubble, FSM holds, busyD = 0.

## Timing
- Reset: all `valid_o`, `ctrl_o`, `beat_o`, `last_o` = 0. FSM IDLE, counter 0, busyD = 0 (provided stall_i = 0).
- Reset takes priority over stall_i and kill_i.
- Latency: a micro-op issued in cycle t appears on stage k outputs in cycle t+1+k.
- A vector instruction occupies Decode for BEATS cycles plus the number of stall cycles.
- Beats reach stage 0 in consecutive cycles unless a stall occurs. Stalls insert bubbles between beats; beat order is preserved.
- Reset mid-sequence: next cycle FSM is IDLE and the pipeline is empty. The partially issued beats are discarded.

## Structure
- Package `vctrl_pkg`:
  - bit-index localparams for the default control word (REGWRITE, MEMTOREG, MEMWRITE, ALUSRC, REGDST, ALUCTRL_LSB)
  - typedef for the FSM state enum {IDLE, ISSUE}
  - function for the beat-width calculation
- Sub-module `pipe_stage`: a single pipeline register with synchronous reset, clear and enable, parametrised by width and holding {valid, last, beat, ctrl}. It is instantiated NSTAGES times via generate.
- Sequencer logic lives inline in `vctrl_pipe`.

## Test plan
- Reset, then a scalar op with ctrlD = 8'hA5 and validD = 1 at cycle 0. Expected: stage 0/1/2 show 8'hA5, valid = 1, last = 1 at cycles 1/2/3. busyD stays 0.
- Vector op, default parameters (BEATS = 2), ctrlD = 8'h3C. Expected: busyD = 1 in cycle 0 and 0 in cycle 1. Stage 0 shows beat 0 (last = 0) at cycle 1 and beat 1 (last = 1) at cycle 2.
- VLEN = 16, LANES = 4, stall_i high in the cycle after beat 1 issues. Expected: stage 0 sequence is beats 0, 1, bubble, 2, 3. busyD stays high until the cycle beat 3 issues.
- kill_i during the ISSUE state after beat 0 of a 4-beat op. Expected: bubble at stage 0 next cycle, FSM in IDLE. A new instruction presented afterwards issues as beat 0.
- stall_i and kill_i asserted together mid-sequence. Expected: same result as kill alone.
- Reset asserted while beats 1–2 are in flight. Expected: all valid_o = 0 on the next cycle, and the next vector op restarts at beat 0.
